muldiv: RTL

MULDIV -- requirements
Module: muldiv

---
 rtl/muldiv.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/muldiv.sv
// ============================================================================
// Module  : muldiv
// Brief   : 32-bit iterative multiply/divide unit with HI/LO result registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;
    localparam logic [4:0] c_LAST    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic [31:0] r_a_raw;
    logic        r_is_div;
    logic        r_sa;
    logic        r_sb;
    logic        r_bzero;

    logic        w_iter_op;
    logic        w_signed_op;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_rem;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [63:0] w_acc_next;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_res;

    // MULT=000, MULTU=001, DIV=010, DIVU=011; bit 0 clear means signed.
    assign w_iter_op   = ~i_op[2];
    assign w_signed_op = ~i_op[2] & ~i_op[0];
    assign w_abs_a     = (w_signed_op && i_a[31]) ? (32'd0 - i_a) : i_a;
    assign w_abs_b     = (w_signed_op && i_b[31]) ? (32'd0 - i_b) : i_b;

    // One radix-2 step: multiply shifts right with add, divide shifts left with restore.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_div_rem  = r_acc[63:31];
    assign w_div_ge   = (w_div_rem >= {1'b0, r_opnd});
    assign w_div_diff = w_div_rem[31:0] - r_opnd;
    assign w_acc_next = r_is_div
                      ? {(w_div_ge ? w_div_diff : w_div_rem[31:0]), r_acc[30:0], w_div_ge}
                      : {w_mul_sum, r_acc[31:1]};

    assign w_quo = r_acc[31:0];
    assign w_rem = r_acc[63:32];

    always_comb begin
        w_res = r_acc;
        if (!r_is_div) begin
            w_res = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
        end else if (r_bzero) begin
            w_res = {r_a_raw, 32'hFFFF_FFFF};
        end else begin
            w_res = {(r_sa ? (32'd0 - w_rem) : w_rem),
                     ((r_sa ^ r_sb) ? (32'd0 - w_quo) : w_quo)};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start && w_iter_op) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_LAST)      w_next = S_FIX;
            S_FIX:                             w_next = S_IDLE;
            default:                           w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt    <= 5'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_a_raw  <= 32'd0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_hi     <= 32'd0;
            o_lo     <= 32'd0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_iter_op) begin
                        r_cnt    <= 5'd0;
                        r_is_div <= i_op[1];
                        r_sa     <= w_signed_op & i_a[31];
                        r_sb     <= w_signed_op & i_b[31];
                        r_a_raw  <= i_a;
                        r_bzero  <= (i_b == 32'd0);
                        r_opnd   <= i_op[1] ? w_abs_b : w_abs_a;
                        r_acc    <= {32'd0, (i_op[1] ? w_abs_a : w_abs_b)};
                        o_busy   <= 1'b1;
                    end else if (i_start && i_op == c_OP_MTHI) begin
                        o_hi <= i_a;
                    end else if (i_start && i_op == c_OP_MTLO) begin
                        o_lo <= i_a;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    o_hi   <= w_res[63:32];
                    o_lo   <= w_res[31:0];
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
